// File: rtl/alu_seq_pkg.sv
// Shared definitions for the ALU-time-shared multiply sequencer:
// the core ALU opcode map and the sequencer state encoding.
package alu_seq_pkg;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_XOR = 4'b0011;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLL = 4'b0111;
  localparam logic [3:0] ALU_SRL = 4'b1000;
  localparam logic [3:0] ALU_SRA = 4'b1001;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    DONE = 2'd2
  } mul_state_t;

endpackage

// File: rtl/alu_mul_sequencer_if.sv
// Bundle of the operand/result handshakes and the shared-ALU request bus.
// The slave side is the sequencer; the master side is everything around it
// (operand producer, result consumer, ALU and its arbiter).
interface alu_mul_sequencer_if #(
  parameter int REG_WIDTH = 32
);

  logic                 in_valid;
  logic                 in_ready;
  logic [REG_WIDTH-1:0] op_a;
  logic [REG_WIDTH-1:0] op_b;
  logic                 mul_hi;
  logic                 out_valid;
  logic                 out_ready;
  logic [REG_WIDTH-1:0] result;
  logic                 busy;
  logic                 alu_req;
  logic                 alu_gnt;
  logic [REG_WIDTH-1:0] alu_in1;
  logic [REG_WIDTH-1:0] alu_in2;
  logic [3:0]           alu_control;
  logic [REG_WIDTH-1:0] alu_result;
  logic                 alu_carry;

  modport master (
    output in_valid, op_a, op_b, mul_hi, out_ready, alu_gnt, alu_result, alu_carry,
    input  in_ready, out_valid, result, busy, alu_req, alu_in1, alu_in2, alu_control
  );

  modport slave (
    input  in_valid, op_a, op_b, mul_hi, out_ready, alu_gnt, alu_result, alu_carry,
    output in_ready, out_valid, result, busy, alu_req, alu_in1, alu_in2, alu_control
  );

endinterface

// File: rtl/alu_mul_sequencer.sv
// Unsigned shift-add multiplier that borrows the core ALU for its adds.
// Each granted cycle adds A (or 0) into the upper partial product and shifts
// {carry, sum, Q} right by one; after REG_WIDTH grants the low or high word
// of the full product is held until the consumer takes it.
module alu_mul_sequencer
  import alu_seq_pkg::*;
#(
  parameter int REG_WIDTH = 32
) (
  input logic               clk,
  input logic               rst_n,
  alu_mul_sequencer_if.slave bus
);

  localparam int CNT_W = $clog2(REG_WIDTH) + 1;
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(REG_WIDTH - 1);

  mul_state_t           state;
  logic [REG_WIDTH-1:0] p_hi;
  logic [REG_WIDTH-1:0] q;
  logic [REG_WIDTH-1:0] a;
  logic [REG_WIDTH-1:0] result_q;
  logic [CNT_W-1:0]     cnt;
  logic                 sel;
  logic                 out_valid_q;

  logic [REG_WIDTH-1:0] p_hi_next;
  logic [REG_WIDTH-1:0] q_next;

  // Shifted partial product formed from the ALU sum and its carry-out
  always_comb begin
    {p_hi_next, q_next} = {bus.alu_carry, bus.alu_result, q[REG_WIDTH-1:1]};
  end

  // Sequencer state, datapath registers and the registered result handshake
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      p_hi        <= '0;
      q           <= '0;
      a           <= '0;
      cnt         <= '0;
      sel         <= 1'b0;
      result_q    <= '0;
      out_valid_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            a     <= bus.op_a;
            q     <= bus.op_b;
            p_hi  <= '0;
            cnt   <= '0;
            sel   <= bus.mul_hi;
            state <= ITER;
          end
        end
        ITER: begin
          if (bus.alu_gnt) begin
            p_hi <= p_hi_next;
            q    <= q_next;
            cnt  <= cnt + CNT_W'(1);
            if (cnt == LAST_ITER) begin
              result_q    <= sel ? p_hi_next : q_next;
              out_valid_q <= 1'b1;
              state       <= DONE;
            end
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Outputs decoded from state only, so the grant never feeds back into the request
  always_comb begin
    bus.in_ready    = rst_n && (state == IDLE);
    bus.busy        = (state == ITER) || (state == DONE);
    bus.alu_req     = (state == ITER);
    bus.alu_control = (state == ITER) ? ALU_ADD : ALU_AND;
    bus.alu_in1     = (state == ITER) ? p_hi : '0;
    bus.alu_in2     = ((state == ITER) && q[0]) ? a : '0;
    bus.out_valid   = out_valid_q;
    bus.result      = result_q;
  end

endmodule

// File: tb/tb_alu_mul_sequencer.sv
// Bench for alu_mul_sequencer: behavioural ALU, a per-cycle product model
// checked on every falling edge, and directed operand vectors with literal results.
module tb_alu_mul_sequencer;

  localparam int W = 32;

  logic clk = 1'b0;
  logic rst_n;

  int vectors     = 0;
  int miscompares = 0;

  // Model state: 0 idle, 1 iterating, 2 result held
  int          m_phase  = 0;
  int          m_grants = 0;
  logic [W-1:0] m_a = '0;
  logic [W-1:0] m_b = '0;
  logic         m_hi = 1'b0;
  logic [63:0]  m_prod = '0;

  alu_mul_sequencer_if #(.REG_WIDTH(W)) bus ();

  alu_mul_sequencer #(.REG_WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Behavioural model of the core ALU
  always_comb begin
    logic [W:0] wide;
    wide           = '0;
    bus.alu_result = '0;
    bus.alu_carry  = 1'b0;
    case (bus.alu_control)
      4'b0000: bus.alu_result = bus.alu_in1 & bus.alu_in2;
      4'b0001: bus.alu_result = bus.alu_in1 | bus.alu_in2;
      4'b0010: begin
        wide = {1'b0, bus.alu_in1} + {1'b0, bus.alu_in2};
        bus.alu_result = wide[W-1:0];
        bus.alu_carry  = wide[W];
      end
      4'b0011: bus.alu_result = bus.alu_in1 ^ bus.alu_in2;
      4'b0110: bus.alu_result = bus.alu_in1 - bus.alu_in2;
      4'b0111: bus.alu_result = bus.alu_in1 << bus.alu_in2[4:0];
      4'b1000: bus.alu_result = bus.alu_in1 >> bus.alu_in2[4:0];
      4'b1001: bus.alu_result = $signed(bus.alu_in1) >>> bus.alu_in2[4:0];
      default: bus.alu_result = '0;
    endcase
  end

  function automatic void cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Per-cycle comparison against the product model, then model advance
  always @(negedge clk) begin
    logic [63:0] mask;
    logic [63:0] partial;
    if (!rst_n) begin
      cmp("rst_out_valid", bus.out_valid, 0);
      cmp("rst_alu_req",   bus.alu_req,   0);
      cmp("rst_busy",      bus.busy,      0);
      cmp("rst_result",    bus.result,    0);
      m_phase  = 0;
      m_grants = 0;
    end else begin
      cmp("in_ready",  bus.in_ready,  m_phase == 0);
      cmp("busy",      bus.busy,      m_phase != 0);
      cmp("alu_req",   bus.alu_req,   m_phase == 1);
      cmp("out_valid", bus.out_valid, m_phase == 2);
      if (m_phase == 1) begin
        mask    = (64'd1 << m_grants) - 64'd1;
        partial = ({32'b0, m_a} * ({32'b0, m_b} & mask)) >> m_grants;
        cmp("alu_control", bus.alu_control, 4'b0010);
        cmp("alu_in1",     bus.alu_in1,     partial[31:0]);
        cmp("alu_in2",     bus.alu_in2,     m_b[m_grants] ? m_a : 32'd0);
      end else begin
        cmp("idle_alu_control", bus.alu_control, 0);
        cmp("idle_alu_in1",     bus.alu_in1,     0);
        cmp("idle_alu_in2",     bus.alu_in2,     0);
      end
      if (m_phase == 2)
        cmp("result", bus.result, m_hi ? m_prod[63:32] : m_prod[31:0]);

      case (m_phase)
        0: if (bus.in_valid) begin
             m_a      = bus.op_a;
             m_b      = bus.op_b;
             m_hi     = bus.mul_hi;
             m_prod   = {32'b0, bus.op_a} * {32'b0, bus.op_b};
             m_grants = 0;
             m_phase  = 1;
           end
        1: if (bus.alu_gnt) begin
             m_grants++;
             if (m_grants == W) m_phase = 2;
           end
        default: if (bus.out_ready) m_phase = 0;
      endcase
    end
  end

  task automatic startOp(input logic [W-1:0] a, input logic [W-1:0] b, input logic hi, input bit toggle);
    @(posedge clk); #1;
    bus.op_a     = a;
    bus.op_b     = b;
    bus.mul_hi   = hi;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.alu_gnt  = toggle ? 1'b0 : 1'b1;
  endtask

  task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b, input logic hi,
                               input bit toggle, output int lat);
    startOp(a, b, hi, toggle);
    lat = 0;
    while (lat < 200) begin
      @(posedge clk); #1;
      lat++;
      if (bus.out_valid) break;
      bus.alu_gnt = toggle ? (lat % 2 == 1) : 1'b1;
    end
  endtask

  task automatic checkOutput(input string name, input logic [W-1:0] exp_result,
                             input int exp_lat, input int lat);
    cmp({name, "_valid"},   bus.out_valid, 1);
    cmp({name, "_result"},  bus.result,    exp_result);
    cmp({name, "_latency"}, lat,           exp_lat);
  endtask

  task automatic consume();
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    cmp("post_handshake_in_ready",  bus.in_ready,  1);
    cmp("post_handshake_out_valid", bus.out_valid, 0);
  endtask

  initial begin
    int lat;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.op_a      = '0;
    bus.op_b      = '0;
    bus.mul_hi    = 1'b0;
    bus.out_ready = 1'b0;
    bus.alu_gnt   = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    cmp("reset_in_ready", bus.in_ready, 1);

    applyStimulus(32'd3, 32'd5, 1'b0, 1'b0, lat);
    checkOutput("mul_3x5", 32'd15, 32, lat);
    consume();

    applyStimulus(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, lat);
    checkOutput("ones_hi", 32'hFFFF_FFFE, 32, lat);
    consume();
    applyStimulus(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, lat);
    checkOutput("ones_lo", 32'h0000_0001, 32, lat);
    consume();

    applyStimulus(32'h1234_5678, 32'h9ABC_DEF0, 1'b1, 1'b1, lat);
    checkOutput("toggle_hi", 32'h0B00_EA4E, 64, lat);

    // Hold the result while a new operand pair is offered; it must be ignored
    bus.op_a     = 32'd9;
    bus.op_b     = 32'd9;
    bus.in_valid = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    cmp("stall_in_ready", bus.in_ready, 0);
    checkOutput("stall_hold", 32'h0B00_EA4E, 64, lat);
    consume();

    applyStimulus(32'h1234_5678, 32'h9ABC_DEF0, 1'b0, 1'b1, lat);
    checkOutput("toggle_lo", 32'h242D_2080, 64, lat);
    consume();

    // Reset in the middle of an operation
    startOp(32'hCAFE_F00D, 32'h1357_9BDF, 1'b1, 1'b0);
    repeat (10) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    cmp("midrst_out_valid", bus.out_valid, 0);
    cmp("midrst_alu_req",   bus.alu_req,   0);
    @(negedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    cmp("midrst_in_ready",  bus.in_ready,  1);
    cmp("midrst_busy",      bus.busy,      0);

    // Consumer already ready before the result exists
    bus.out_ready = 1'b1;
    applyStimulus(32'd7, 32'd6, 1'b0, 1'b0, lat);
    checkOutput("mul_7x6", 32'd42, 32, lat);
    consume();

    applyStimulus(32'hDEAD_BEEF, 32'd0, 1'b0, 1'b0, lat);
    checkOutput("zero_b", 32'd0, 32, lat);
    consume();

    repeat (2) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
